// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared AHB-Lite code constants and the responder FSM state type.
// Also used by the companion master emulator, so keep the encodings stable.
package ahb_lite_mem_slave_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Wait counter preload; a zero wait-state build never enters ST_WAIT.
    function automatic logic [3:0] wait_load(input int ws);
        return (ws > 0) ? 4'(ws - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_lite_strobe.sv
// Byte-lane strobe decode from transfer size and low address bits.
// Also flags unsupported sizes and misaligned half/word accesses.
module ahb_lite_strobe
    import ahb_lite_mem_slave_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       err
);

    always_comb begin
        strb = 4'b0000;
        err  = 1'b0;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                err  = addr_lo[0];
            end
            HSIZE_WORD: begin
                strb = 4'b1111;
                err  = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite responder with a word-organised scratch memory, programmable wait
// states and the two-cycle ERROR response.
module ahb_lite_mem_slave
    import ahb_lite_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** IDX_W;
    localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_STATES);

    state_t           state;
    state_t           state_nx;
    state_t           accept_nx;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       strb_q;
    logic             write_q;
    logic [3:0]       cnt;
    logic [31:0]      mem [WORDS];

    logic [3:0] strb;
    logic       lane_err;
    logic       range_err;
    logic       addr_err;
    logic       ready_state;
    logic       accept;
    logic       unused_inputs;

    assign unused_inputs = &{1'b0, HBURST, HPROT, HMASTLOCK};

    ahb_lite_strobe u_strobe (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .strb    (strb),
        .err     (lane_err)
    );

    assign range_err   = (HADDR >> ADDR_WIDTH) != 32'd0;
    assign addr_err    = lane_err | range_err;
    // Only states that drive HREADYOUT high can take a new address phase.
    assign ready_state = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept      = HSEL & HREADY & ready_state &
                         ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_comb begin
        accept_nx = ST_IDLE;
        if (accept) begin
            if (addr_err)             accept_nx = ST_ERR1;
            else if (WAIT_STATES > 0) accept_nx = ST_WAIT;
            else                      accept_nx = ST_DATA;
        end

        state_nx = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: state_nx = accept_nx;
            ST_WAIT: if (cnt == 4'd0) state_nx = ST_DATA;
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            strb_q  <= 4'b0000;
            write_q <= 1'b0;
            cnt     <= 4'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx_q   <= HADDR[ADDR_WIDTH-1:2];
                strb_q  <= strb;
                write_q <= HWRITE & ~addr_err;
                cnt     <= WAIT_LOAD;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Commit on the edge that ends DATA; contents are deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (state == ST_DATA && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state == ST_DATA && !write_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench: zero-wait and two-wait-state responders on a shared bus,
// directed scenarios plus randomized traffic against a byte-lane memory model.
module tb_ahb_lite_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0, sel2;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        force0, force2;
    logic [31:0] rdata0, rdata2;
    logic        ro0, ro2, resp0, resp2;
    logic        hready0, hready2;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [256];

    assign hready0 = ro0 & ~force0;
    assign hready2 = ro2 & ~force2;

    always #5 clk = ~clk;

    ahb_lite_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready0),
        .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb_lite_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready2),
        .HRDATA(rdata2), .HREADYOUT(ro2), .HRESP(resp2)
    );

    function automatic logic get_ro(input int d);
        return (d == 1) ? ro2 : ro0;
    endfunction

    function automatic logic get_resp(input int d);
        return (d == 1) ? resp2 : resp0;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 1) ? rdata2 : rdata0;
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        if (sz == 3'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [2:0] sz,
                                        input logic [31:0] wd);
        int nbytes = 1 << sz;
        int w = int'(a / 4);
        for (int k = 0; k < nbytes; k++) begin
            int lane = int'(a % 4) + k;
            model_mem[w][8*lane +: 8] = wd[8*lane +: 8];
        end
    endfunction

    task automatic bus_idle();
        sel0 = 1'b0; sel2 = 1'b0; htrans = 2'b00;
    endtask

    // Walk one data phase: count HREADYOUT-low cycles and capture the final cycle.
    task automatic data_phase(input int d, output logic [31:0] rd, output logic rsp,
                              output int lows, output int lowr, output bit to);
        lows = 0; lowr = 0; to = 1'b1; rd = 32'd0; rsp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (get_ro(d)) begin
                rd = get_rd(d); rsp = get_resp(d); to = 1'b0;
                break;
            end
            lows++;
            if (get_resp(d)) lowr++;
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                        output int lows, output int lowr, output bit to);
        @(negedge clk);
        if (d == 1) sel2 = 1'b1; else sel0 = 1'b1;
        haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
        @(posedge clk); #1;
        bus_idle();
        hwdata = wd;
        data_phase(d, rd, rsp, lows, lowr, to);
        if (d == 1 && wr && !model_err(a, sz)) model_write(a, sz, wd);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", ro0); end
        checks++; if (ro2 !== 1'b1) begin failures++; $display("FAIL reset_ready2 got=%b exp=1", ro2); end
        checks++; if (resp0 !== 1'b0 || resp2 !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", resp0, resp2); end
        checks++; if (rdata0 !== 32'd0 || rdata2 !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata0, rdata2); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sel0 = 1'b1; haddr = 32'h004; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        hwdata = 32'h1234_5678; hwrite = 1'b0;
        @(negedge clk);
        checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL b2b_write_ready got=%b exp=1", ro0); end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        checks++; if (ro0 !== 1'b1 || resp0 !== 1'b0) begin failures++; $display("FAIL b2b_read_ready got=%b/%b exp=1/0", ro0, resp0); end
        checks++; if (rdata0 !== 32'h1234_5678) begin failures++; $display("FAIL b2b_read_data got=%h exp=12345678", rdata0); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        xfer(1, 1'b1, 32'h000, 3'd2, 32'hA5A5_5A5A, rd, rsp, lows, lowr, to);
        checks++; if (to || lows != 2 || rsp !== 1'b0) begin failures++; $display("FAIL ws_write got lows=%0d resp=%b to=%0d exp lows=2 resp=0", lows, rsp, to); end
        xfer(1, 1'b0, 32'h000, 3'd2, 32'd0, rd, rsp, lows, lowr, to);
        checks++; if (to || lows != 2 || lowr != 0 || rsp !== 1'b0) begin failures++; $display("FAIL ws_read_timing got lows=%0d lowr=%0d resp=%b exp 2/0/0", lows, lowr, rsp); end
        checks++; if (rd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL ws_read_data got=%h exp=a5a55a5a", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        xfer(1, 1'b1, 32'h008, 3'd2, 32'hFFFF_FFFF, rd, rsp, lows, lowr, to);
        xfer(1, 1'b1, 32'h009, 3'd0, 32'h0000_AB00, rd, rsp, lows, lowr, to);
        xfer(1, 1'b0, 32'h008, 3'd2, 32'd0, rd, rsp, lows, lowr, to);
        checks++; if (rd !== 32'hFFFF_ABFF) begin failures++; $display("FAIL byte_write got=%h exp=ffffabff", rd); end
        xfer(1, 1'b1, 32'h00A, 3'd1, 32'hCDEF_0000, rd, rsp, lows, lowr, to);
        xfer(1, 1'b0, 32'h008, 3'd2, 32'd0, rd, rsp, lows, lowr, to);
        checks++; if (rd !== 32'hCDEF_ABFF) begin failures++; $display("FAIL half_write got=%h exp=cdefabff", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        xfer(1, 1'b1, 32'h002, 3'd2, 32'hDEAD_BEEF, rd, rsp, lows, lowr, to);
        checks++; if (to || lows != 1 || lowr != 1 || rsp !== 1'b1) begin failures++; $display("FAIL err_misaligned got lows=%0d lowr=%0d resp=%b exp 1/1/1", lows, lowr, rsp); end
        xfer(1, 1'b1, 32'h400, 3'd2, 32'hDEAD_BEEF, rd, rsp, lows, lowr, to);
        checks++; if (to || lows != 1 || lowr != 1 || rsp !== 1'b1) begin failures++; $display("FAIL err_range got lows=%0d lowr=%0d resp=%b exp 1/1/1", lows, lowr, rsp); end
        xfer(1, 1'b1, 32'h000, 3'd3, 32'hDEAD_BEEF, rd, rsp, lows, lowr, to);
        checks++; if (to || lows != 1 || rsp !== 1'b1) begin failures++; $display("FAIL err_size got lows=%0d resp=%b exp 1/1", lows, rsp); end
        xfer(1, 1'b0, 32'h000, 3'd2, 32'd0, rd, rsp, lows, lowr, to);
        checks++; if (rd !== 32'hA5A5_5A5A || rsp !== 1'b0) begin failures++; $display("FAIL err_mem_unchanged got=%h resp=%b exp=a5a55a5a/0", rd, rsp); end
    endtask

    task automatic test_busy();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        int bad = 0;
        @(negedge clk);
        sel2 = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h000; hsize = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            hwdata = 32'h0;
            @(negedge clk);
            if (ro2 !== 1'b1 || resp2 !== 1'b0) bad++;
        end
        bus_idle();
        checks++; if (bad != 0) begin failures++; $display("FAIL busy_zero_wait got bad_cycles=%0d exp=0", bad); end
        xfer(1, 1'b0, 32'h000, 3'd2, 32'd0, rd, rsp, lows, lowr, to);
        checks++; if (rd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL busy_mem_unchanged got=%h exp=a5a55a5a", rd); end
    endtask

    task automatic test_hready_hold();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        @(negedge clk);
        force2 = 1'b1;
        sel2 = 1'b1; haddr = 32'h008; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ro2 !== 1'b1) begin failures++; $display("FAIL hready_low_ignored got=%b exp=1", ro2); end
        force2 = 1'b0;
        @(posedge clk); #1;
        bus_idle();
        data_phase(1, rd, rsp, lows, lowr, to);
        checks++; if (to || lows != 2 || rd !== 32'hCDEF_ABFF) begin failures++; $display("FAIL hready_high_accept got lows=%0d data=%h exp 2/cdefabff", lows, rd); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        xfer(1, 1'b1, 32'h010, 3'd2, 32'h1111_1111, rd, rsp, lows, lowr, to);
        @(negedge clk);
        sel2 = 1'b1; haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'h2222_2222;
        @(negedge clk);
        checks++; if (ro2 !== 1'b0) begin failures++; $display("FAIL rst_mid_in_wait got=%b exp=0", ro2); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ro2 !== 1'b1 || resp2 !== 1'b0 || rdata2 !== 32'd0) begin failures++; $display("FAIL rst_mid_outputs got=%b/%b/%h exp=1/0/0", ro2, resp2, rdata2); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'h010, 3'd2, 32'd0, rd, rsp, lows, lowr, to);
        checks++; if (rd !== 32'h1111_1111) begin failures++; $display("FAIL rst_mid_no_commit got=%h exp=11111111", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic rsp; int lows, lowr; bit to;
        logic [31:0] a, wd, exp_rd;
        logic [2:0] sz;
        bit wr, err;
        int exp_lows;
        for (int w = 0; w < 16; w++) begin
            xfer(1, 1'b1, 32'(w * 4), 3'd2, $urandom, rd, rsp, lows, lowr, to);
        end
        for (int it = 0; it < 80; it++) begin
            int kind = $urandom_range(0, 9);
            int widx = $urandom_range(0, 15);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            sz = 3'($urandom_range(0, 2));
            a = 32'(widx * 4 + $urandom_range(0, 3));
            if (kind == 0) sz = 3'd3;
            else if (kind == 1) a = a | (32'd1 << $urandom_range(10, 31));
            else if (kind == 2) begin sz = 3'($urandom_range(1, 2)); a = 32'(widx * 4 + 1); end
            else a = a & ~((32'd1 << sz) - 32'd1);
            err = model_err(a, sz);
            exp_rd = (wr || err) ? 32'd0 : model_mem[widx];
            exp_lows = err ? 1 : 2;
            xfer(1, wr, a, sz, wd, rd, rsp, lows, lowr, to);
            checks++;
            if (to || lows != exp_lows || lowr != (err ? 1 : 0) || rsp !== err) begin
                failures++;
                $display("FAIL rand_resp it=%0d addr=%h size=%0d got lows=%0d lowr=%0d resp=%b exp lows=%0d resp=%b",
                         it, a, sz, lows, lowr, rsp, exp_lows, err);
            end
            checks++;
            if (rd !== exp_rd) begin
                failures++;
                $display("FAIL rand_data it=%0d addr=%h wr=%0d got=%h exp=%h", it, a, wr, rd, exp_rd);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; force0 = 1'b0; force2 = 1'b0;
        sel0 = 1'b0; sel2 = 1'b0; htrans = 2'b00; haddr = 32'd0;
        hwrite = 1'b0; hsize = 3'd2; hwdata = 32'd0;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
        test_errors();
        test_busy();
        test_hready_hold();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
